mig7_arbiter: RTL and testbench

MIG7_ARBITER -- requirements
Module: mig7_arbiter

---
 rtl/mig7_pkg.sv | 12 +
 rtl/mig7_tag_fifo.sv | 53 +++++
 rtl/mig7_arbiter.sv | 141 ++++++++++++++
 tb/tb_mig7_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig7_pkg.sv
// Shared constants and types for the two-client MIG 7-series command arbiter.
package mig7_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mig7_tag_fifo.sv
// 1-bit wide synchronous FIFO holding the client ID of each read in flight.
module mig7_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig7_arbiter.sv
// Round-robin arbiter sharing one MIG 7-series app interface between two clients,
// with in-order routing of read data back to the requesting client.
module mig7_arbiter
  import mig7_pkg::*;
#(
  parameter int AW        = 28,
  parameter int DW        = 128,
  parameter int MW        = 16,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_write,
  input  logic [1:0][AW-1:0]            req_addr,
  input  logic [1:0][DW-1:0]            req_wdata,
  input  logic [1:0][MW-1:0]            req_wmask,
  output logic [1:0]                    rsp_valid,
  output logic [DW-1:0]                 rsp_data,
  output logic [AW-1:0]                 app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  output logic [DW-1:0]                 app_wdf_data,
  output logic                          app_wdf_end,
  output logic [MW-1:0]                 app_wdf_mask,
  output logic                          app_wdf_wren,
  input  logic [DW-1:0]                 app_rd_data,
  input  logic                          app_rd_data_valid,
  input  logic                          app_rdy,
  input  logic                          app_wdf_rdy,
  input  logic                          init_calib_complete,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_orphan
);

  arb_state_t state;
  arb_state_t state_nxt;

  logic       ptr;
  logic [1:0] elig;
  logic       gnt_vld;
  logic       gnt_id;
  logic       cur_id;
  logic       en_pend;
  logic       wr_pend;
  logic       tag_push;
  logic       tag_pop;
  logic       tag_head;
  logic       tag_full;
  logic       tag_empty;

  assign app_wdf_end = 1'b1;

  // A read is only eligible while the tag FIFO can still take its ID.
  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = rst_n && (state == IDLE) && init_calib_complete && req_valid[i] &&
                (req_write[i] || !tag_full);
    end
  end

  assign gnt_vld   = |elig;
  assign gnt_id    = (elig == 2'b11) ? ptr : elig[1];
  assign req_ready = {gnt_vld & gnt_id, gnt_vld & ~gnt_id};

  assign en_pend = app_en && !app_rdy;
  assign wr_pend = app_wdf_wren && !app_wdf_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   if (!en_pend && !wr_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command stage: capture the winner, then hold app_en / app_wdf_wren until each
  // handshake completes on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      cur_id       <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        ptr          <= ~gnt_id;
        cur_id       <= gnt_id;
        app_en       <= 1'b1;
        app_wdf_wren <= req_write[gnt_id];
        app_addr     <= req_addr[gnt_id];
        app_cmd      <= req_write[gnt_id] ? CMD_WRITE : CMD_READ;
        app_wdf_data <= req_wdata[gnt_id];
        app_wdf_mask <= req_wmask[gnt_id];
      end else begin
        if (app_en && app_rdy)            app_en       <= 1'b0;
        if (app_wdf_wren && app_wdf_rdy)  app_wdf_wren <= 1'b0;
      end
    end
  end

  assign tag_push = app_en && app_rdy && (app_cmd == CMD_READ);
  assign tag_pop  = app_rd_data_valid && !tag_empty;

  mig7_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (tag_push),
    .push_id (cur_id),
    .pop     (tag_pop),
    .head_id (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (outstanding)
  );

  // Response stage: one-cycle registered return of read data to the head client.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= tag_pop ? {tag_head, ~tag_head} : 2'b00;
      if (tag_pop) rsp_data <= app_rd_data;
      if (app_rd_data_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig7_arbiter.sv
// Directed and randomized bench for mig7_arbiter with a queue-based reference model.
module tb_mig7_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int TD = 16;
  localparam int CW = $clog2(TD) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_write;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][DW-1:0]   req_wdata;
  logic [1:0][MW-1:0]   req_wmask;
  logic [1:0]           rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic [AW-1:0]        app_addr;
  logic [2:0]           app_cmd;
  logic                 app_en;
  logic [DW-1:0]        app_wdf_data;
  logic                 app_wdf_end;
  logic [MW-1:0]        app_wdf_mask;
  logic                 app_wdf_wren;
  logic [DW-1:0]        app_rd_data;
  logic                 app_rd_data_valid;
  logic                 app_rdy;
  logic                 app_wdf_rdy;
  logic                 init_calib_complete;
  logic [CW-1:0]        outstanding;
  logic                 err_orphan;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mig7_arbiter #(.AW(AW), .DW(DW), .MW(MW), .TAG_DEPTH(TD)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_wmask           (req_wmask),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .init_calib_complete (init_calib_complete),
    .outstanding         (outstanding),
    .err_orphan          (err_orphan)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input logic c);
    return c ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    app_rd_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, wr_cnt, ngr, rt_q[$];
    logic rc_q[$], rdq[$];
    logic exp_g, last_g, exp_pend, dropped;
    logic [1:0] exp_vec;
    logic [DW-1:0] exp_dat, wd;
    logic [MW-1:0] wm;
    logic [AW-1:0] wa;

    // Reset state, with requests already pending
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    req_wmask = '0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    init_calib_complete = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_wdf_wren", 128'(app_wdf_wren), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_err_orphan", 128'(err_orphan), 128'(0));
    chk("rst_app_addr", 128'(app_addr), 128'(0));
    chk("rst_app_cmd", 128'(app_cmd), 128'(0));
    chk("rst_wdf_data", app_wdf_data, 128'(0));
    chk("rst_wdf_mask", 128'(app_wdf_mask), 128'(0));
    chk("rst_rsp_data", rsp_data, 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("wdf_end_const", 128'(app_wdf_end), 128'(1));

    // Single client-0 write
    rst_n = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    wd = 128'hCAFEBABE_12345678_AA55AA55_55AA55AA;
    wm = MW'($urandom);
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[0] = AW'(28'h10);
    req_wdata[0] = wd;
    req_wmask[0] = wm;
    #1;
    chk("wr0_ready", 128'(req_ready), 128'(2'b01));
    en_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      req_valid = 2'b00;
      if (app_en) begin
        en_cnt++;
        chk("wr0_addr", 128'(app_addr), 128'(28'h10));
        chk("wr0_cmd", 128'(app_cmd), 128'(3'b000));
      end
      if (app_wdf_wren) begin
        wr_cnt++;
        chk("wr0_data", app_wdf_data, wd);
        chk("wr0_mask", 128'(app_wdf_mask), 128'(wm));
      end
    end
    chk("wr0_en_pulses", 128'(en_cnt), 128'(1));
    chk("wr0_wren_pulses", 128'(wr_cnt), 128'(1));

    // Both clients read continuously; grants alternate and data returns 5 cycles later
    do_reset();
    req_write = 2'b00;
    req_valid = 2'b11;
    app_rdy = 1'b1;
    exp_g = 1'b0;
    last_g = 1'b0;
    exp_pend = 1'b0;
    dropped = 1'b0;
    ngr = 0;
    exp_vec = 2'b00;
    exp_dat = '0;
    #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (exp_pend) begin
        chk("rr_rsp_valid", 128'(rsp_valid), 128'(exp_vec));
        chk("rr_rsp_data", rsp_data, exp_dat);
        exp_pend = 1'b0;
      end else begin
        chk("rr_rsp_idle", 128'(rsp_valid), 128'(2'b00));
      end
      if (req_ready != 2'b00) begin
        chk("rr_grant", 128'(req_ready), 128'(oh(exp_g)));
        last_g = req_ready[1];
        exp_g = ~exp_g;
        ngr++;
      end
      if (app_en && app_cmd == 3'b001) begin
        rt_q.push_back(cyc + 5);
        rc_q.push_back(last_g);
      end
      app_rd_data_valid = 1'b0;
      if (rt_q.size() > 0 && rt_q[0] <= cyc) begin
        void'(rt_q.pop_front());
        app_rd_data_valid = 1'b1;
        app_rd_data = rnd_data();
        exp_vec = oh(rc_q.pop_front());
        exp_dat = app_rd_data;
        exp_pend = 1'b1;
      end
      if (cyc >= 40 && req_ready == 2'b00) dropped = 1'b1;
      if (dropped) req_valid = 2'b00;
      @(negedge clk);
      #1;
    end
    app_rd_data_valid = 1'b0;
    chk("rr_grants_seen", 128'(ngr >= 16), 128'(1));
    chk("rr_outstanding_drained", 128'(outstanding), 128'(0));
    chk("rr_queue_drained", 128'(rt_q.size()), 128'(0));

    // Write with app_wdf_rdy held low for 3 cycles after app_rdy
    do_reset();
    wa = AW'($urandom);
    wd = rnd_data();
    req_addr[1] = wa;
    req_wdata[1] = wd;
    req_valid = 2'b10;
    req_write = 2'b10;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b0;
    #1;
    chk("wr1_ready", 128'(req_ready), 128'(2'b10));
    en_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      req_valid = 2'b00;
      if (app_en) begin
        en_cnt++;
        chk("wr1_addr", 128'(app_addr), 128'(wa));
      end
      if (app_wdf_wren) begin
        wr_cnt++;
        chk("wr1_data", app_wdf_data, wd);
      end
      if (i == 3) app_wdf_rdy = 1'b1;
    end
    chk("wr1_en_cycles", 128'(en_cnt), 128'(1));
    chk("wr1_wren_cycles", 128'(wr_cnt), 128'(4));
    req_valid = 2'b01;
    req_write = 2'b00;
    #1;
    chk("wr1_back_idle", 128'(req_ready), 128'(2'b01));
    req_valid = 2'b00;

    // Fill the tag FIFO with random-client reads, then drain in order
    do_reset();
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    for (int cyc = 0; cyc < 300 && outstanding != CW'(TD); cyc++) begin
      req_write = 2'b00;
      req_valid = 2'($urandom_range(1, 3));
      #1;
      if (req_ready != 2'b00) rdq.push_back(req_ready[1]);
      @(negedge clk);
    end
    #1;
    chk("full_outstanding", 128'(outstanding), 128'(TD));
    chk("full_grants", 128'(rdq.size()), 128'(TD));
    req_valid = 2'b11;
    req_write = 2'b00;
    #1;
    chk("full_read_blocked", 128'(req_ready), 128'(2'b00));
    @(negedge clk);
    #1;
    chk("full_read_blocked2", 128'(req_ready), 128'(2'b00));
    req_write = 2'b11;
    #1;
    chk("full_write_granted", 128'(req_ready == 2'b01 || req_ready == 2'b10), 128'(1));
    @(negedge clk);
    #1;
    req_valid = 2'b00;
    for (int k = 0; k < TD && rdq.size() > 0; k++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = rnd_data();
      exp_dat = app_rd_data;
      exp_vec = oh(rdq.pop_front());
      @(negedge clk);
      #1;
      chk("drain_rsp_valid", 128'(rsp_valid), 128'(exp_vec));
      chk("drain_rsp_data", rsp_data, exp_dat);
    end
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("drain_outstanding", 128'(outstanding), 128'(0));
    chk("drain_rsp_idle", 128'(rsp_valid), 128'(2'b00));
    chk("drain_no_orphan", 128'(err_orphan), 128'(0));

    // Orphan read data
    exp_dat = rsp_data;
    app_rd_data_valid = 1'b1;
    app_rd_data = rnd_data();
    @(negedge clk);
    #1;
    app_rd_data_valid = 1'b0;
    chk("orphan_flag", 128'(err_orphan), 128'(1));
    chk("orphan_rsp_valid", 128'(rsp_valid), 128'(2'b00));
    chk("orphan_outstanding", 128'(outstanding), 128'(0));
    @(negedge clk);
    #1;
    chk("orphan_sticky", 128'(err_orphan), 128'(1));

    // Calibration gating and in-flight completion after calibration drops
    init_calib_complete = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    #1;
    chk("nocal_ready", 128'(req_ready), 128'(2'b00));
    @(negedge clk);
    #1;
    chk("nocal_no_cmd", 128'(app_en), 128'(0));
    init_calib_complete = 1'b1;
    app_rdy = 1'b0;
    req_valid = 2'b01;
    #1;
    chk("cal_ready", 128'(req_ready), 128'(2'b01));
    @(negedge clk);
    #1;
    req_valid = 2'b00;
    init_calib_complete = 1'b0;
    chk("cal_issue_en", 128'(app_en), 128'(1));
    @(negedge clk);
    #1;
    chk("cal_en_held", 128'(app_en), 128'(1));
    app_rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("cal_drop_completes", 128'(app_en), 128'(0));
    chk("cal_drop_outstanding", 128'(outstanding), 128'(1));

    // Reset asserted while a command is in ISSUE
    init_calib_complete = 1'b1;
    app_rdy = 1'b0;
    req_valid = 2'b10;
    req_addr[1] = AW'($urandom) | AW'(1);
    #1;
    chk("rstmid_ready", 128'(req_ready), 128'(2'b10));
    @(negedge clk);
    #1;
    chk("rstmid_en_before", 128'(app_en), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rstmid_app_en", 128'(app_en), 128'(0));
    chk("rstmid_wdf_wren", 128'(app_wdf_wren), 128'(0));
    chk("rstmid_app_addr", 128'(app_addr), 128'(0));
    chk("rstmid_app_cmd", 128'(app_cmd), 128'(0));
    chk("rstmid_wdf_data", app_wdf_data, 128'(0));
    chk("rstmid_wdf_mask", 128'(app_wdf_mask), 128'(0));
    chk("rstmid_outstanding", 128'(outstanding), 128'(0));
    chk("rstmid_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rstmid_rsp_valid", 128'(rsp_valid), 128'(2'b00));
    chk("rstmid_rsp_data", rsp_data, 128'(0));
    chk("rstmid_err_orphan", 128'(err_orphan), 128'(0));
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
